// File: rtl/bcd_to_excess3.sv
// Registered packed-BCD to Excess-3 converter with per-digit illegal-digit flags.
// One cycle of latency, full throughput, no backpressure.
module bcd_to_excess3 #(
    parameter int DIGITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [4*DIGITS-1:0] bcd,
    output logic                out_valid,
    output logic [4*DIGITS-1:0] excess3,
    output logic [DIGITS-1:0]   err_mask,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    logic              out_valid_d, out_valid_q;
    logic [W-1:0]      excess3_d, excess3_q;
    logic [DIGITS-1:0] err_mask_d, err_mask_q;
    logic              err_d, err_q;

    // Without a valid input, the data registers keep their last conversion.
    always_comb begin
        out_valid_d = in_valid;
        excess3_d   = excess3_q;
        err_mask_d  = err_mask_q;
        err_d       = err_q;
        if (in_valid) begin
            for (int k = 0; k < DIGITS; k++) begin
                excess3_d[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
                err_mask_d[k]       = (bcd[4*k +: 4] > 4'd9);
            end
            err_d = |err_mask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            excess3_q   <= '0;
            err_mask_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            excess3_q   <= excess3_d;
            err_mask_q  <= err_mask_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign excess3   = excess3_q;
    assign err_mask  = err_mask_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_excess3.sv
// Bench for bcd_to_excess3: one single-digit and one four-digit instance,
// expected responses queued at issue time and popped by per-instance monitors.
module tb_bcd_to_excess3;

    // Handshake: a result is consumed by the monitor on every cycle out_valid=1;
    // there is no ready, the DUT never stalls.

    logic        clk;
    logic        rst;

    logic        in_valid1;
    logic [3:0]  bcd1;
    logic        out_valid1;
    logic [3:0]  excess3_1;
    logic [0:0]  err_mask1;
    logic        err1;

    logic        in_valid4;
    logic [15:0] bcd4;
    logic        out_valid4;
    logic [15:0] excess3_4;
    logic [3:0]  err_mask4;
    logic        err4;

    // {err, excess3}
    logic [4:0]  exp1_q[$];
    // {err, err_mask, excess3}
    logic [20:0] exp4_q[$];

    int n_checks;
    int n_pass;

    bcd_to_excess3 #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .bcd(bcd1),
        .out_valid(out_valid1), .excess3(excess3_1), .err_mask(err_mask1), .err(err1)
    );

    bcd_to_excess3 #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .bcd(bcd4),
        .out_valid(out_valid4), .excess3(excess3_4), .err_mask(err_mask4), .err(err4)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- drivers ----------------
    // Inputs are applied, then the sampling edge passes; on return outputs are updated.
    task automatic drive1(input logic v, input logic [3:0] b, input logic push, input logic [4:0] e);
        in_valid1 = v;
        bcd1      = b;
        if (push) exp1_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [15:0] b, input logic push, input logic [20:0] e);
        in_valid4 = v;
        bcd4      = b;
        if (push) exp4_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (out_valid1) begin
            if (exp1_q.size() == 0) begin
                check("dut1 unexpected output", {27'd0, err1, excess3_1}, 32'hFFFF_FFFF);
            end else begin
                logic [4:0] e;
                e = exp1_q.pop_front();
                check("dut1 excess3", {28'd0, excess3_1}, {28'd0, e[3:0]});
                check("dut1 err", {31'd0, err1}, {31'd0, e[4]});
                check("dut1 err_mask", {31'd0, err_mask1}, {31'd0, e[4]});
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid4) begin
            if (exp4_q.size() == 0) begin
                check("dut4 unexpected output", {11'd0, err4, err_mask4, excess3_4}, 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp4_q.pop_front();
                check("dut4 excess3", {16'd0, excess3_4}, {16'd0, e[15:0]});
                check("dut4 err_mask", {28'd0, err_mask4}, {28'd0, e[19:16]});
                check("dut4 err", {31'd0, err4}, {31'd0, e[20]});
            end
        end
    end

    // Hand-computed Excess-3 table for 0..15, {err, code}
    logic [4:0] sweep_exp [16];
    initial begin
        sweep_exp[0]  = 5'b0_0011; sweep_exp[1]  = 5'b0_0100;
        sweep_exp[2]  = 5'b0_0101; sweep_exp[3]  = 5'b0_0110;
        sweep_exp[4]  = 5'b0_0111; sweep_exp[5]  = 5'b0_1000;
        sweep_exp[6]  = 5'b0_1001; sweep_exp[7]  = 5'b0_1010;
        sweep_exp[8]  = 5'b0_1011; sweep_exp[9]  = 5'b0_1100;
        sweep_exp[10] = 5'b1_1101; sweep_exp[11] = 5'b1_1110;
        sweep_exp[12] = 5'b1_1111; sweep_exp[13] = 5'b1_0000;
        sweep_exp[14] = 5'b1_0001; sweep_exp[15] = 5'b1_0010;
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid1 = 1'b1;
        bcd1      = 4'h7;
        in_valid4 = 1'b1;
        bcd4      = 16'h7777;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid1", {31'd0, out_valid1}, 32'd0);
        check("reset excess3_1", {28'd0, excess3_1}, 32'd0);
        check("reset err1", {31'd0, err1}, 32'd0);
        check("reset out_valid4", {31'd0, out_valid4}, 32'd0);
        check("reset excess3_4", {16'd0, excess3_4}, 32'd0);
        check("reset err_mask4", {28'd0, err_mask4}, 32'd0);

        rst       = 1'b0;
        in_valid4 = 1'b0;
        bcd4      = 16'h0000;
        drive1(1'b1, 4'h7, 1'b1, 5'b0_1010);

        for (int i = 0; i < 16; i++) drive1(1'b1, 4'(i), 1'b1, sweep_exp[i]);

        // Gap: the last valid result (2 -> 0101) must be held
        drive1(1'b1, 4'h2, 1'b1, 5'b0_0101);
        drive1(1'b0, 4'h8, 1'b0, 5'b0);
        check("gap out_valid1", {31'd0, out_valid1}, 32'd0);
        check("gap hold excess3_1", {28'd0, excess3_1}, 32'h5);
        check("gap hold err1", {31'd0, err1}, 32'd0);

        // Multi-digit vectors
        drive4(1'b1, 16'h9305, 1'b1, {1'b0, 4'b0000, 16'hC638});
        drive4(1'b1, 16'h1A2F, 1'b1, {1'b1, 4'b0101, 16'h4D52});
        drive4(1'b1, 16'h0000, 1'b1, {1'b0, 4'b0000, 16'h3333});
        drive4(1'b1, 16'hFFFF, 1'b1, {1'b1, 4'b1111, 16'h2222});
        drive4(1'b1, 16'hD9E4, 1'b1, {1'b1, 4'b1010, 16'h0C17});
        drive4(1'b1, 16'h4826, 1'b1, {1'b0, 4'b0000, 16'h7B59});
        drive4(1'b0, 16'h1111, 1'b0, 21'd0);
        check("dut4 gap out_valid", {31'd0, out_valid4}, 32'd0);
        check("dut4 gap hold excess3", {16'd0, excess3_4}, 32'h7B59);

        // Mid-stream reset: the conversion of 2 is discarded
        drive1(1'b1, 4'h1, 1'b1, 5'b0_0100);
        rst = 1'b1;
        drive1(1'b1, 4'h2, 1'b0, 5'b0);
        check("midreset out_valid1", {31'd0, out_valid1}, 32'd0);
        check("midreset excess3_1", {28'd0, excess3_1}, 32'd0);
        rst = 1'b0;
        drive1(1'b1, 4'h3, 1'b1, 5'b0_0110);
        drive1(1'b0, 4'h0, 1'b0, 5'b0);

        repeat (3) @(posedge clk);
        #1;
        check("dut1 expected queue drained", exp1_q.size(), 32'd0);
        check("dut4 expected queue drained", exp4_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
